// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/device bundle: opcode and status in, selects and strobes out.
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int ULA_W    = 5
);
    logic [OPCODE_W-1:0] opcode;
    logic                br_cond;
    logic                alu_done;
    logic                in_valid;
    logic                out_ready;
    logic                resume;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic                MuxBankSelect;
    logic                MUXULASelect;
    logic                MUXDMSelect;
    logic [ULA_W-1:0]    ULAcode;
    logic                RegWrite;
    logic                WriteFlag;
    logic                alu_start;
    logic                inputControl;
    logic                in_ack;
    logic                outputControl;
    logic                halted;
    logic                illegal;
    logic                err_timeout;

    // Control unit side
    modport master (
        input  opcode, br_cond, alu_done, in_valid, out_ready, resume,
        output ir_write, pc_write, pc_src, MuxBankSelect, MUXULASelect, MUXDMSelect,
               ULAcode, RegWrite, WriteFlag, alu_start, inputControl, in_ack,
               outputControl, halted, illegal, err_timeout
    );

    // Datapath / device side
    modport slave (
        output opcode, br_cond, alu_done, in_valid, out_ready, resume,
        input  ir_write, pc_write, pc_src, MuxBankSelect, MUXULASelect, MUXDMSelect,
               ULAcode, RegWrite, WriteFlag, alu_start, inputControl, in_ack,
               outputControl, halted, illegal, err_timeout
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with ALU and I/O stalls,
// resumable HALT, sticky illegal-opcode flag and an ALU watchdog.
module multicycle_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int ULA_W    = 5,
    parameter int TIMEOUT  = 256
) (
    input logic clock,
    input logic reset,
    multicycle_control_unit_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC     = 4'd3;
    localparam logic [3:0] S_WAIT_ALU = 4'd4;
    localparam logic [3:0] S_WAIT_IO  = 4'd5;
    localparam logic [3:0] S_MEM      = 4'd6;
    localparam logic [3:0] S_WB       = 4'd7;
    localparam logic [3:0] S_HALT     = 4'd8;

    // Instruction classes derived from the latched opcode
    localparam logic [3:0] C_NOP  = 4'd0;
    localparam logic [3:0] C_WB   = 4'd1;
    localparam logic [3:0] C_ALU  = 4'd2;
    localparam logic [3:0] C_LW   = 4'd3;
    localparam logic [3:0] C_SW   = 4'd4;
    localparam logic [3:0] C_BR   = 4'd5;
    localparam logic [3:0] C_JMP  = 4'd6;
    localparam logic [3:0] C_JMPR = 4'd7;
    localparam logic [3:0] C_IN   = 4'd8;
    localparam logic [3:0] C_OUT  = 4'd9;

    logic [3:0]          state_reg, state_next;
    logic [OPCODE_W-1:0] op_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                illegal_reg, err_reg;

    logic                live_high, lat_high, live_bad, lat_bad, live_hlt;
    logic [3:0]          cls;
    logic [4:0]          ula5;
    logic                imm_sel, bank_sel, active, wd_expire;
    logic                ir_write, pc_write, reg_write, write_flag, alu_start;
    logic                out_valid, in_ack, halted;
    logic [1:0]          pc_src;

    // Bits above the 6-bit opcode space only exist for wide opcodes
    generate
        if (OPCODE_W > 6) begin : g_wide
            assign live_high = |bus.opcode[OPCODE_W-1:6];
            assign lat_high  = |op_reg[OPCODE_W-1:6];
        end else begin : g_narrow
            assign live_high = 1'b0;
            assign lat_high  = 1'b0;
        end
    endgenerate

    assign live_bad  = live_high || (bus.opcode[5:0] > 6'h1D);
    assign lat_bad   = lat_high  || (op_reg[5:0]     > 6'h1D);
    assign live_hlt  = !live_high && (bus.opcode[5:0] == 6'h17);
    assign wd_expire = (cnt_reg == CNT_W'(TIMEOUT - 1));

    // Opcode decode: class, ALU code, immediate select, destination-bank select.
    // Bank select only matters for register-writing ALU ops and OUT; illegal codes decode as NOP.
    always_comb begin
        cls      = C_NOP;
        ula5     = 5'h00;
        imm_sel  = 1'b0;
        bank_sel = 1'b0;
        if (!lat_bad) begin
            case (op_reg[5:0])
                6'h00: begin cls = C_WB;   ula5 = 5'h00; bank_sel = 1'b1; end // ADD
                6'h01: begin cls = C_WB;   ula5 = 5'h01; bank_sel = 1'b1; end // SUB
                6'h02: begin cls = C_WB;   ula5 = 5'h00; imm_sel  = 1'b1; end // ADDI
                6'h03: begin cls = C_WB;   ula5 = 5'h01; imm_sel  = 1'b1; end // SUBI
                6'h04: begin cls = C_ALU;  ula5 = 5'h05; bank_sel = 1'b1; end // MULT
                6'h05: begin cls = C_WB;   ula5 = 5'h09; bank_sel = 1'b1; end // NOT
                6'h06: begin cls = C_WB;   ula5 = 5'h0A; bank_sel = 1'b1; end // AND
                6'h07: begin cls = C_WB;   ula5 = 5'h0B; bank_sel = 1'b1; end // OR
                6'h08: begin cls = C_WB;   ula5 = 5'h0C; bank_sel = 1'b1; end // XOR
                6'h09: begin cls = C_WB;   ula5 = 5'h04; bank_sel = 1'b1; end // SLT
                6'h0A: begin cls = C_WB;   ula5 = 5'h07; bank_sel = 1'b1; end // SHFL
                6'h0B: begin cls = C_WB;   ula5 = 5'h08; bank_sel = 1'b1; end // SHFR
                6'h0C: begin cls = C_LW;   ula5 = 5'h00; imm_sel  = 1'b1; end // LW
                6'h0D: begin cls = C_WB;   ula5 = 5'h00; imm_sel  = 1'b1; end // LI
                6'h0E: begin cls = C_SW;   ula5 = 5'h00; imm_sel  = 1'b1; end // SW
                6'h0F: begin cls = C_BR;   ula5 = 5'h0D; end                  // BEQ
                6'h10: begin cls = C_BR;   ula5 = 5'h10; end                  // BNEQ
                6'h11: begin cls = C_BR;   ula5 = 5'h11; end                  // BEQZ
                6'h12: begin cls = C_JMP;  ula5 = 5'h02; end                  // JMP
                6'h13: begin cls = C_JMPR; ula5 = 5'h00; end                  // JMPR
                6'h15: begin cls = C_IN;   imm_sel  = 1'b1; end               // IN
                6'h16: begin cls = C_OUT;  bank_sel = 1'b1; end               // OUT
                6'h18: begin cls = C_WB;   ula5 = 5'h00; imm_sel  = 1'b1; end // MOVE
                6'h19: begin cls = C_ALU;  ula5 = 5'h12; bank_sel = 1'b1; end // DIV
                6'h1A: begin cls = C_ALU;  ula5 = 5'h13; bank_sel = 1'b1; end // remainder
                6'h1B: begin cls = C_WB;   ula5 = 5'h06; bank_sel = 1'b1; end // SGT
                6'h1C: begin cls = C_WB;   ula5 = 5'h0E; bank_sel = 1'b1; end // SLE
                6'h1D: begin cls = C_WB;   ula5 = 5'h0F; bank_sel = 1'b1; end // SGE
                default: ;                                                    // NOP, HLT
            endcase
        end
    end

    // Next-state logic; alu_done is checked before the watchdog so it wins a tie
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = live_hlt ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_WB:         state_next = S_WB;
                    C_LW, C_SW:   state_next = S_MEM;
                    C_ALU:        state_next = S_WAIT_ALU;
                    C_IN, C_OUT:  state_next = S_WAIT_IO;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_WAIT_ALU: begin
                if (bus.alu_done)   state_next = S_WB;
                else if (wd_expire) state_next = S_HALT;
            end
            S_WAIT_IO: begin
                if (cls == C_IN && bus.in_valid)        state_next = S_WB;
                else if (cls == C_OUT && bus.out_ready) state_next = S_FETCH;
            end
            S_MEM:    state_next = (cls == C_LW) ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = bus.resume ? S_FETCH : S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Opcode latch at the end of DECODE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                   op_reg <= '0;
        else if (state_reg == S_DECODE) op_reg <= bus.opcode;
    end

    // Watchdog counter: held at zero outside WAIT_ALU, saturating inside it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                     cnt_reg <= '0;
        else if (state_reg != S_WAIT_ALU) cnt_reg <= '0;
        else if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + 1'b1;
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            illegal_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            if (state_reg == S_DECODE && live_bad) illegal_reg <= 1'b1;
            if (state_reg == S_WAIT_ALU && !bus.alu_done && wd_expire) err_reg <= 1'b1;
        end
    end

    // Per-state strobes and PC source
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        write_flag = 1'b0;
        alu_start  = 1'b0;
        out_valid  = 1'b0;
        in_ack     = 1'b0;
        halted     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_EXEC: begin
                case (cls)
                    C_ALU:  alu_start = 1'b1;
                    C_BR:   begin pc_write = bus.br_cond; pc_src = 2'b01; end
                    C_JMP:  begin pc_write = 1'b1;        pc_src = 2'b10; end
                    C_JMPR: begin pc_write = 1'b1;        pc_src = 2'b11; end
                    default: ;
                endcase
            end
            S_MEM:     write_flag = (cls == C_SW);
            S_WAIT_IO: out_valid  = (cls == C_OUT);
            S_WB: begin
                reg_write = 1'b1;
                in_ack    = (cls == C_IN);
            end
            S_HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // Selects are only driven while an instruction is past DECODE
    assign active = (state_reg == S_EXEC) || (state_reg == S_WAIT_ALU) ||
                    (state_reg == S_WAIT_IO) || (state_reg == S_MEM) || (state_reg == S_WB);

    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.pc_src        = pc_src;
    assign bus.MuxBankSelect = active && bank_sel;
    assign bus.MUXULASelect  = active && imm_sel;
    assign bus.MUXDMSelect   = active && (cls != C_LW);
    assign bus.ULAcode       = active ? ULA_W'(ula5) : '0;
    assign bus.RegWrite      = reg_write;
    assign bus.WriteFlag     = write_flag;
    assign bus.alu_start     = alu_start;
    assign bus.inputControl  = active && (cls == C_IN);
    assign bus.in_ack        = in_ack;
    assign bus.outputControl = out_valid;
    assign bus.halted        = halted;
    assign bus.illegal       = illegal_reg || (state_reg == S_DECODE && live_bad);
    assign bus.err_timeout   = err_reg;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-level scoreboard bench for multicycle_control_unit.
`timescale 1ns/1ps
module tb_multicycle_control_unit;
    localparam int OPCODE_W = 7;
    localparam int ULA_W    = 5;
    localparam int TIMEOUT  = 16;

    localparam int K_WB = 0, K_NOP = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JMPR = 5;
    localparam int K_ALU = 6, K_TO = 7, K_IN = 8, K_OUT = 9, K_HLT = 10, K_ILL = 11;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       bank;
        logic       ulasel;
        logic       dmsel;
        logic [4:0] ula;
        logic       reg_write;
        logic       write_flag;
        logic       alu_start;
        logic       in_ctl;
        logic       in_ack;
        logic       out_ctl;
        logic       halted;
        logic       illegal;
        logic       err;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic sticky_ill = 1'b0;
    logic sticky_err = 1'b0;
    obs_t exp_q[$];
    string tag_q[$];
    obs_t got;

    multicycle_control_unit_if #(.OPCODE_W(OPCODE_W), .ULA_W(ULA_W)) bus();

    multicycle_control_unit #(.OPCODE_W(OPCODE_W), .ULA_W(ULA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign got = {bus.ir_write, bus.pc_write, bus.pc_src, bus.MuxBankSelect, bus.MUXULASelect,
                  bus.MUXDMSelect, bus.ULAcode, bus.RegWrite, bus.WriteFlag, bus.alu_start,
                  bus.inputControl, bus.in_ack, bus.outputControl, bus.halted, bus.illegal,
                  bus.err_timeout};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, want);
        end
    endtask

    // Scoreboard consumer: one expected output vector per clock cycle
    always @(negedge clock) begin : mon
        obs_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, 32'(got), 32'(e));
        end
    end

    function automatic obs_t sel_of(input logic [4:0] ula, input logic bank, input logic ulasel,
                                    input logic dmsel, input logic inctl);
        obs_t s;
        s        = '0;
        s.ula    = ula;
        s.bank   = bank;
        s.ulasel = ulasel;
        s.dmsel  = dmsel;
        s.in_ctl = inctl;
        return s;
    endfunction

    function automatic obs_t stk(input obs_t v);
        obs_t r;
        r         = v;
        r.illegal = v.illegal | sticky_ill;
        r.err     = v.err | sticky_err;
        return r;
    endfunction

    // Drive one cycle of inputs and queue the expected outputs; entered at posedge+1
    task automatic step(input string tag, input obs_t e, input logic brc, input logic ad,
                        input logic iv, input logic ordy, input logic res);
        bus.br_cond   = brc;
        bus.alu_done  = ad;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.resume    = res;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [OPCODE_W-1:0] op, input int kind,
                             input obs_t s, input int n, input logic flag);
        obs_t v;
        bus.opcode = op;
        v = '0; v.ir_write = 1'b1; v.pc_write = 1'b1;
        step({tag, ".fetch"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (kind == K_ILL) sticky_ill = 1'b1;
        step({tag, ".decode"}, stk('0), 1'b0, 1'b0, 1'b0, 1'b0, (kind == K_HLT) && flag);
        case (kind)
            K_WB: begin
                step({tag, ".exec"}, stk(s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                v = s; v.reg_write = 1'b1;
                step({tag, ".wb"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            K_NOP, K_ILL: step({tag, ".exec"}, stk(s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            K_LW: begin
                step({tag, ".exec"}, stk(s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                step({tag, ".mem"}, stk(s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                v = s; v.reg_write = 1'b1;
                step({tag, ".wb"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            K_SW: begin
                step({tag, ".exec"}, stk(s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                v = s; v.write_flag = 1'b1;
                step({tag, ".mem"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            K_BR: begin
                v = s; v.pc_src = 2'b01; v.pc_write = flag;
                step({tag, ".exec"}, stk(v), flag, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            K_JMPR: begin
                v = s; v.pc_src = 2'b11; v.pc_write = 1'b1;
                step({tag, ".exec"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            K_ALU: begin
                v = s; v.alu_start = 1'b1;
                step({tag, ".exec"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                for (int i = 1; i <= n; i++)
                    step({tag, ".wait"}, stk(s), 1'b0, (i == n), 1'b0, 1'b0, 1'b0);
                v = s; v.reg_write = 1'b1;
                step({tag, ".wb"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            K_TO: begin
                v = s; v.alu_start = 1'b1;
                step({tag, ".exec"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                for (int i = 1; i <= n; i++)
                    step({tag, ".wait"}, stk(s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                sticky_err = 1'b1;
                v = '0; v.halted = 1'b1;
                step({tag, ".halt"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                step({tag, ".halt_res"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            K_IN: begin
                step({tag, ".exec"}, stk(s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i <= n; i++)
                    step({tag, ".wait"}, stk(s), 1'b0, 1'b0, (i == n), 1'b0, 1'b0);
                v = s; v.reg_write = 1'b1; v.in_ack = 1'b1;
                step({tag, ".wb"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            K_OUT: begin
                step({tag, ".exec"}, stk(s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                v = s; v.out_ctl = 1'b1;
                for (int i = 0; i <= n; i++)
                    step({tag, ".wait"}, stk(v), 1'b0, 1'b0, 1'b0, (i == n), 1'b0);
            end
            K_HLT: begin
                v = '0; v.halted = 1'b1;
                for (int i = 1; i <= n; i++)
                    step({tag, ".halt"}, stk(v), 1'b0, 1'b0, 1'b0, 1'b0, (i == n));
            end
            default: ;
        endcase
        $display("instr %s op=%h done", tag, op);
    endtask

    initial begin
        obs_t v;
        bus.opcode    = '0;
        bus.br_cond   = 1'b0;
        bus.alu_done  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.resume    = 1'b0;

        // Reset state and release into one IDLE cycle
        repeat (2) @(posedge clock);
        #1;
        chk("rst_outs", 32'(got), 32'(0));
        reset = 1'b1;
        step("idle", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // SW interrupted by reset during MEM
        bus.opcode = 7'h0E;
        v = '0; v.ir_write = 1'b1; v.pc_write = 1'b1;
        step("swr.fetch", v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("swr.decode", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("swr.exec", sel_of(5'h00, 1'b0, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("swr.mem_wf", 32'(got.write_flag), 32'(1));
        #2 reset = 1'b0;
        #1;
        chk("swr.async_wf", 32'(got.write_flag), 32'(0));
        chk("swr.async_all", 32'(got), 32'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        $display("instr swr op=0e reset mid-MEM");
        step("idle2", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_instr("ADD",    7'h00, K_WB,   sel_of(5'h00, 1'b1, 1'b0, 1'b1, 1'b0), 0,  1'b0);
        run_instr("SLE",    7'h1C, K_WB,   sel_of(5'h0E, 1'b1, 1'b0, 1'b1, 1'b0), 0,  1'b0);
        run_instr("ADDI",   7'h02, K_WB,   sel_of(5'h00, 1'b0, 1'b1, 1'b1, 1'b0), 0,  1'b0);
        run_instr("NOP",    7'h14, K_NOP,  sel_of(5'h00, 1'b0, 1'b0, 1'b1, 1'b0), 0,  1'b0);
        run_instr("LW",     7'h0C, K_LW,   sel_of(5'h00, 1'b0, 1'b1, 1'b0, 1'b0), 0,  1'b0);
        run_instr("SW",     7'h0E, K_SW,   sel_of(5'h00, 1'b0, 1'b1, 1'b1, 1'b0), 0,  1'b0);
        run_instr("BEQ_T",  7'h0F, K_BR,   sel_of(5'h0D, 1'b0, 1'b0, 1'b1, 1'b0), 0,  1'b1);
        run_instr("BEQ_F",  7'h0F, K_BR,   sel_of(5'h0D, 1'b0, 1'b0, 1'b1, 1'b0), 0,  1'b0);
        run_instr("JMPR",   7'h13, K_JMPR, sel_of(5'h00, 1'b0, 1'b0, 1'b1, 1'b0), 0,  1'b0);
        run_instr("DIV",    7'h19, K_ALU,  sel_of(5'h12, 1'b1, 1'b0, 1'b1, 1'b0), 10, 1'b0);
        run_instr("MULT16", 7'h04, K_ALU,  sel_of(5'h05, 1'b1, 1'b0, 1'b1, 1'b0), 16, 1'b0);
        run_instr("IN",     7'h15, K_IN,   sel_of(5'h00, 1'b0, 1'b1, 1'b1, 1'b1), 5,  1'b0);
        run_instr("OUT",    7'h16, K_OUT,  sel_of(5'h00, 1'b1, 1'b0, 1'b1, 1'b0), 3,  1'b0);
        run_instr("HLT",    7'h17, K_HLT,  '0,                                    4,  1'b0);
        run_instr("HLT_R",  7'h17, K_HLT,  '0,                                    1,  1'b1);
        run_instr("ILL3F",  7'h3F, K_ILL,  sel_of(5'h00, 1'b0, 1'b0, 1'b1, 1'b0), 0,  1'b0);
        run_instr("ILL40",  7'h40, K_ILL,  sel_of(5'h00, 1'b0, 1'b0, 1'b1, 1'b0), 0,  1'b0);
        run_instr("MOD_TO", 7'h1A, K_TO,   sel_of(5'h13, 1'b1, 1'b0, 1'b1, 1'b0), 16, 1'b0);
        run_instr("NOP_END",7'h14, K_NOP,  sel_of(5'h00, 1'b0, 1'b0, 1'b1, 1'b0), 0,  1'b0);

        // Sticky flags are cleared by reset alone
        #2 reset = 1'b0;
        #1;
        chk("rst_sticky", 32'(got), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle, state-machine control unit for the processor core; replaces the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and produces all datapath selects and write strobes. It stalls on a multi-cycle ALU (MULT/DIV/MOD) and on valid/ready handshakes with the input and output devices. It also supports a resumable halt, illegal-opcode detection and an ALU watchdog.

## Interface
Parameters:
- OPCODE_W, 6, opcode width (≥6); any set bit above bit 5 makes the opcode illegal
- ULA_W, 5, ALU code width (≥5); codes are zero-extended
- TIMEOUT, 256, maximum number of WAIT_ALU cycles before a watchdog halt (≥2)

Ports (reset is asynchronous, active-low):
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  opcode from instruction memory; latched at the end of the DECODE cycle
- br_cond  in  1  branch condition from the ALU; 1 = take; sampled in EXEC
- alu_done  in  1  multi-cycle ALU result is ready
- in_valid  in  1  input device has data
- out_ready  in  1  output device accepts data
- resume  in  1  leave HALT
- ir_write, pc_write  out  1  instruction-register and PC write strobes
- pc_src  out  2  PC source: 00 = PC+1, 01 = branch target, 10 = jump immediate, 11 = register
- MuxBankSelect, MUXULASelect, MUXDMSelect  out  1  destination-register select, immediate-operand select, writeback select (0 = data memory)
- ULAcode  out  ULA_W  ALU operation
- RegWrite, WriteFlag  out  1  register-bank write and data-memory write strobes
- alu_start  out  1  one-cycle start pulse for MULT/DIV/MOD
- inputControl, in_ack  out  1  input-port writeback select; input consumed
- outputControl  out  1  output valid
- halted, illegal, err_timeout  out  1  HALT status; sticky illegal-opcode flag; sticky watchdog flag

## Operation
- Opcode map, as opcode/ULAcode pairs in hex:
  - Writeback ops: ADD 00/00, SUB 01/01, ADDI 02/00, SUBI 03/01, NOT 05/09, AND 06/0A, OR 07/0B, XOR 08/0C, SLT 09/04, SHFL 0A/07, SHFR 0B/08, LI 0D/00, MOVE 18/00, SGT 1B/06, SLE 1C/0E, SGE 1D/0F.
  - Multi-cycle ALU ops: MULT 04/05, DIV 19/12, MOD 1A/13.
  - Memory: LW 0C/00, SW 0E/00.
  - Control flow: BEQ 0F/0D, BNEQ 10/10, BEQZ 11/11, JMP 12/02, JMPR 13/00.
  - Other: NOP 14, IN 15, OUT 16, HLT 17.
- Select signals:
  - MUXULASelect=1 for ADDI, SUBI, LI, MOVE, LW, SW and IN.
  - MuxBankSelect=1 for register-register ops and OUT.
  - MUXDMSelect=0 only for LW.
- Selects are combinational from the latched opcode. They are valid from the cycle after DECODE until the instruction ends, and are 0 in IDLE, FETCH, DECODE and HALT.
- States: IDLE, FETCH, DECODE, EXEC, WAIT_ALU, WAIT_IO, MEM, WB, HALT.
  - IDLE → FETCH, unconditionally.
  - FETCH (ir_write=1, pc_write=1, pc_src=00) → DECODE.
  - DECODE → EXEC, except HLT → HALT.
  - EXEC:
    - Writeback ops → WB.
    - LW and SW → MEM.
    - MULT/DIV/MOD: alu_start=1 → WAIT_ALU.
    - IN and OUT → WAIT_IO.
    - Branches: pc_write=br_cond, pc_src=01 → FETCH.
    - JMP: pc_write=1, pc_src=10 → FETCH. JMPR: pc_write=1, pc_src=11 → FETCH.
    - NOP and illegal opcodes → FETCH.
  - MEM: WriteFlag=1 for SW → FETCH; LW → WB.
  - WAIT_ALU: alu_done=1 → WB.
  - WAIT_IO:
    - IN: stay until in_valid=1, then → WB.
    - OUT: outputControl=1 held; stay until out_ready=1, then → FETCH.
  - WB: RegWrite=1; in_ack=1 when the opcode is IN → FETCH.
  - HALT: halted=1; resume=1 → FETCH.
- Strobes (ir_write, pc_write, RegWrite, WriteFlag, alu_start, in_ack) are single-cycle and asserted only in the states listed above.
- Illegal opcodes: any code above 1D, or any set bit above bit 5. Set illegal=1 in DECODE and execute as NOP. The flag is cleared only by reset.
- Watchdog:
  - The counter is cleared on entry to WAIT_ALU. It is $clog2(TIMEOUT) bits wide and saturates.
  - If the counter reaches TIMEOUT-1 while alu_done=0 → HALT with err_timeout=1 (sticky).
  - If alu_done and the timeout coincide, alu_done wins.
- NOP does not write the register bank.

## Timing
- Reset assertion: asynchronous entry to IDLE. All outputs go to 0 immediately, including the sticky flags. Any in-flight strobe, such as WriteFlag in MEM, drops in the same cycle.
- After reset release: one IDLE cycle, then FETCH.
- Latencies, FETCH to next FETCH:
  - Writeback ops: 4 cycles.
  - LW: 5. SW: 4.
  - Branches, jumps, NOP: 3.
  - MULT/DIV/MOD: 4 + number of WAIT_ALU cycles.
  - IN: 4 + number of WAIT_IO cycles. OUT: 3 + number of WAIT_IO cycles.
- A handshake input that is high on the first wait cycle advances the state on the next edge.
- in_ack occurs exactly once, in the WB cycle after in_valid is sampled high.
- The OUT transfer completes on the edge where outputControl=1 and out_ready=1.
- resume is level-sampled in HALT. When resume=1 on the HLT DECODE cycle, the HALT state still lasts at least 1 cycle.

## Test plan
- Reset and first fetch:
  - Stimulus: reset=0 mid-SW MEM cycle.
  - Required: WriteFlag drops asynchronously and all outputs are 0.
  - After release: 1 IDLE cycle, then FETCH with ir_write=1, pc_write=1, pc_src=00.
- Writeback timing:
  - ADD (00): RegWrite=1 only in the 4th cycle, with ULAcode=00000, MuxBankSelect=1, MUXDMSelect=1.
  - NOP (14): RegWrite never asserted.
- Memory ops:
  - LW (0C): RegWrite in the 5th cycle with MUXDMSelect=0.
  - SW (0E): WriteFlag=1 for exactly 1 cycle (the 4th); RegWrite never asserted.
- Control flow:
  - BEQ (0F) with br_cond=1: EXEC has pc_write=1, pc_src=01.
  - BEQ with br_cond=0: pc_write=0.
  - JMPR (13): pc_src=11.
  - All three take 3 cycles.
- Multi-cycle ALU:
  - DIV (19) with alu_done after 10 WAIT_ALU cycles: a single alu_start pulse, ULAcode=10010, WB on the next cycle.
  - With TIMEOUT=16 and alu_done held 0: HALT after 16 WAIT_ALU cycles, err_timeout=1.
- I/O, halt and illegal opcode:
  - IN (15) with in_valid low for 5 cycles: stalls, then WB with in_ack=1, RegWrite=1, inputControl=1.
  - HLT (17): halted=1 until resume=1, then FETCH.
  - Opcode 3F: illegal=1, then FETCH after 3 cycles.
